// File: rtl/present_masked_pkg.sv
// rtl/present_masked_pkg.sv - shared constants, FSM states and nibble helper for the masked PRESENT S-box layer
package present_masked_pkg;

  localparam int NIBBLES = 16;
  localparam int NIB_W   = 4;
  localparam int SHARE_W = NIBBLES * NIB_W;
  localparam int IDX_W   = 4;
  localparam int RND_W   = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Pick nibble k out of a single share; never mixes shares.
  function automatic logic [NIB_W-1:0] get_nibble(input logic [SHARE_W-1:0] s,
                                                  input logic [IDX_W-1:0]   k);
    return s[k*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/present_token_pipe.sv
// rtl/present_token_pipe.sv - valid + nibble index shift register tracking nibbles inside the S-box
module present_token_pipe
  import present_masked_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [DEPTH-1:0] r_valid;
  logic [IDX_W-1:0] r_idx [DEPTH];

  // Shift tokens one stage per cycle; bubbles carry index 0 so no stale index lingers.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_idx[i] <= '0;
    end else begin
      r_valid  <= {r_valid[DEPTH-2:0], i_valid};
      r_idx[0] <= i_valid ? i_idx : '0;
      for (int i = 1; i < DEPTH; i++) r_idx[i] <= r_idx[i-1];
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/present_sbox_layer_ctrl.sv
// rtl/present_sbox_layer_ctrl.sv - sequences 16 masked nibbles through an external 3-share PRESENT S-box
module present_sbox_layer_ctrl
  import present_masked_pkg::*;
#(
  parameter int SBOX_LAT = 3,
  parameter int R_DELAY  = 1
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic [SHARE_W-1:0] state1_i,
  input  logic [SHARE_W-1:0] state2_i,
  input  logic [SHARE_W-1:0] state3_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [RND_W-1:0]   rnd_i,
  input  logic               rnd_valid_i,
  output logic               rnd_ack_o,
  output logic [NIB_W-1:0]   sb_in1_o,
  output logic [NIB_W-1:0]   sb_in2_o,
  output logic [NIB_W-1:0]   sb_in3_o,
  output logic [RND_W-1:0]   sb_r_o,
  input  logic [NIB_W-1:0]   sb_out1_i,
  input  logic [NIB_W-1:0]   sb_out2_i,
  input  logic [NIB_W-1:0]   sb_out3_i,
  output logic [SHARE_W-1:0] state1_o,
  output logic [SHARE_W-1:0] state2_o,
  output logic [SHARE_W-1:0] state3_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               busy_o
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_k;
  logic [SHARE_W-1:0] r_s1, r_s2, r_s3;
  logic [SHARE_W-1:0] r_o1, r_o2, r_o3;
  logic               w_feed;
  logic               w_accept;
  logic               w_tok_valid;
  logic [IDX_W-1:0]   w_tok_idx;

  // State register.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; a nibble is fed only when randomness is available.
  always_comb begin
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    w_feed      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FEED;
        end
      end
      ST_FEED: begin
        if (rnd_valid_i) begin
          w_feed = 1'b1;
          if (r_k == LAST_IDX) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_tok_valid && (w_tok_idx == LAST_IDX)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the three input shares and step the feed index.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      r_k  <= '0;
    end else if (w_accept) begin
      r_s1 <= state1_i;
      r_s2 <= state2_i;
      r_s3 <= state3_i;
      r_k  <= '0;
    end else if (w_feed) begin
      r_k <= r_k + IDX_W'(1);
    end
  end

  // Shares go out only in a feed cycle, zero otherwise, so no share value is held stale.
  assign sb_in1_o  = w_feed ? get_nibble(r_s1, r_k) : '0;
  assign sb_in2_o  = w_feed ? get_nibble(r_s2, r_k) : '0;
  assign sb_in3_o  = w_feed ? get_nibble(r_s3, r_k) : '0;
  assign rnd_ack_o = w_feed;

  generate
    if (R_DELAY == 0) begin : g_rnd_direct
      assign sb_r_o = w_feed ? rnd_i : '0;
    end else begin : g_rnd_delay
      logic [RND_W-1:0] r_rnd [R_DELAY];

      // Delay the acknowledged word so it meets its nibble at the randomness stage.
      always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
          for (int i = 0; i < R_DELAY; i++) r_rnd[i] <= '0;
        end else begin
          r_rnd[0] <= w_feed ? rnd_i : '0;
          for (int i = 1; i < R_DELAY; i++) r_rnd[i] <= r_rnd[i-1];
        end
      end

      assign sb_r_o = r_rnd[R_DELAY-1];
    end
  endgenerate

  present_token_pipe #(
    .DEPTH (SBOX_LAT)
  ) u_token_pipe (
    .clk     (clk),
    .rst_n_i (rst_n_i),
    .i_valid (w_feed),
    .i_idx   (r_k),
    .o_valid (w_tok_valid),
    .o_idx   (w_tok_idx)
  );

  // Capture each result share into its own nibble slot when its token leaves the pipe.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_o1 <= '0;
      r_o2 <= '0;
      r_o3 <= '0;
    end else if (w_accept) begin
      r_o1 <= '0;
      r_o2 <= '0;
      r_o3 <= '0;
    end else if (w_tok_valid) begin
      r_o1[w_tok_idx*NIB_W +: NIB_W] <= sb_out1_i;
      r_o2[w_tok_idx*NIB_W +: NIB_W] <= sb_out2_i;
      r_o3[w_tok_idx*NIB_W +: NIB_W] <= sb_out3_i;
    end
  end

  assign state1_o = r_o1;
  assign state2_o = r_o2;
  assign state3_o = r_o3;

endmodule

// File: tb/tb_present_sbox_layer_ctrl.sv
// tb/tb_present_sbox_layer_ctrl.sv - table-driven bench for the masked PRESENT S-box layer controller
module tb_present_sbox_layer_ctrl;

  localparam int L  = 3;
  localparam int RD = 1;
  localparam int RI = (RD > 0) ? RD - 1 : 0;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [63:0] state1_i, state2_i, state3_i;
  logic        in_valid_i, in_ready_o;
  logic [7:0]  rnd_i;
  logic        rnd_valid_i, rnd_ack_o;
  logic [3:0]  sb_in1_o, sb_in2_o, sb_in3_o;
  logic [7:0]  sb_r_o;
  logic [3:0]  sb_out1_i, sb_out2_i, sb_out3_i;
  logic [63:0] state1_o, state2_o, state3_o;
  logic        out_valid_o, out_ready_i, busy_o;

  present_sbox_layer_ctrl #(.SBOX_LAT(L), .R_DELAY(RD)) dut (
    .clk(clk), .rst_n_i(rst_n_i),
    .state1_i(state1_i), .state2_i(state2_i), .state3_i(state3_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rnd_i(rnd_i), .rnd_valid_i(rnd_valid_i), .rnd_ack_o(rnd_ack_o),
    .sb_in1_o(sb_in1_o), .sb_in2_o(sb_in2_o), .sb_in3_o(sb_in3_o), .sb_r_o(sb_r_o),
    .sb_out1_i(sb_out1_i), .sb_out2_i(sb_out2_i), .sb_out3_i(sb_out3_i),
    .state1_o(state1_o), .state2_o(state2_o), .state3_o(state3_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // PRESENT S-box: nibble x of this word is S(x).
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h2174_8FE3_DA09_B65C;
    return t[x*4 +: 4];
  endfunction

  function automatic logic [7:0] rnd_of(input int n);
    return 8'(n * 29 + 7) ^ 8'h5C;
  endfunction

  // Masked S-box model: shares fed at a negedge come back L cycles later.
  logic       m_v [0:L];
  logic [3:0] m_x [0:L];
  logic [7:0] m_r [0:L];
  logic [7:0] exp_r;
  int ack_total = 0;
  int bub_viol  = 0;
  int r_viol    = 0;

  always_comb begin
    exp_r = 8'h00;
    if (RD == 0) begin
      if (rnd_ack_o) exp_r = rnd_i;
    end else if (m_v[RI]) begin
      exp_r = m_r[RI];
    end
  end

  always @(negedge clk) begin
    if (!rst_n_i) begin
      for (int j = 0; j <= L; j++) begin
        m_v[j] <= 1'b0;
        m_x[j] <= 4'h0;
        m_r[j] <= 8'h00;
      end
    end else begin
      m_v[0] <= rnd_ack_o;
      m_x[0] <= sb_in1_o ^ sb_in2_o ^ sb_in3_o;
      m_r[0] <= rnd_i;
      for (int j = 1; j <= L; j++) begin
        m_v[j] <= m_v[j-1];
        m_x[j] <= m_x[j-1];
        m_r[j] <= m_r[j-1];
      end
      if (rnd_ack_o) ack_total <= ack_total + 1;
      if (!rnd_ack_o && ((sb_in1_o | sb_in2_o | sb_in3_o) != 4'h0)) bub_viol <= bub_viol + 1;
      if (sb_r_o !== exp_r) r_viol <= r_viol + 1;
    end
  end

  assign sb_out1_i = m_r[L][3:0];
  assign sb_out2_i = m_r[L][7:4];
  assign sb_out3_i = sbox(m_x[L]) ^ m_r[L][3:0] ^ m_r[L][7:4];

  typedef struct {
    logic [63:0] u;
    logic [63:0] s2;
    logic [63:0] s3;
    logic [63:0] exp;
    int          bub_k;
    int          bub_len;
    int          lat;
  } vec_t;

  vec_t vecs[6];
  int   n_vec = 0;
  int   n_err = 0;
  int   g_base, g_bub_k, g_bub_left;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Step edges (edge index counted from the acceptance edge = 0) until out_valid_o or stop_edge.
  task automatic wait_result(input int stop_edge, output int lat);
    int e;
    e   = -1;
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      e++;
      #2;
      if (out_valid_o) begin
        lat = e;
        return;
      end
      if (e == stop_edge) return;
      in_valid_i = 1'b0;
      if (g_bub_left > 0 && (ack_total - g_base) == g_bub_k) begin
        rnd_valid_i = 1'b0;
        g_bub_left--;
      end else begin
        rnd_valid_i = 1'b1;
      end
      rnd_i = rnd_of(ack_total);
    end
  endtask

  task automatic start_op(input vec_t v);
    g_base     = ack_total;
    g_bub_k    = v.bub_k;
    g_bub_left = v.bub_len;
    state1_i   = v.u ^ v.s2 ^ v.s3;
    state2_i   = v.s2;
    state3_i   = v.s3;
    in_valid_i = 1'b1;
    rnd_valid_i = 1'b1;
    rnd_i      = rnd_of(ack_total);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat, bv, rv;
    logic [63:0] e1;
    bv = bub_viol;
    rv = r_viol;
    start_op(v);
    wait_result(1000, lat);
    for (int k = 0; k < 16; k++) e1[k*4 +: 4] = rnd_of(g_base + k) & 8'h0F;
    chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
    chk({tag, "_xor"}, state1_o ^ state2_o ^ state3_o, v.exp);
    chk({tag, "_share1"}, state1_o, e1);
    chk({tag, "_bubble_zero"}, 64'(bub_viol - bv), 64'd0);
    chk({tag, "_sb_r_align"}, 64'(r_viol - rv), 64'd0);
    if (out_ready_i) begin
      @(posedge clk);
      #2;
      chk({tag, "_release"}, {61'd0, in_ready_o, out_valid_o, busy_o}, 64'h4);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] h1, h2, h3;
    logic        ok;
    int          lat;

    vecs[0] = '{64'h0, 64'h0, 64'h0, 64'hCCCC_CCCC_CCCC_CCCC, 0, 0, 19};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 64'h3C5A_9E17_D2B4_6F08, 64'hA1F0_4C7E_8B29_D365,
                64'hC56B_90AD_3EF8_4712, 0, 0, 19};
    vecs[2] = '{64'h0123_4567_89AB_CDEF, 64'h7E21_05C9_BB3D_48A6, 64'h19F4_E26A_0C57_93DB,
                64'hC56B_90AD_3EF8_4712, 7, 5, 24};
    vecs[3] = '{64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_0F0F_F0F0, 64'h1234_5678_9ABC_DEF0,
                64'h2174_8FE3_DA09_B65C, 0, 0, 19};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hC3A5_5A3C_0000_FFFF, 64'h8181_7E7E_2424_DBDB,
                64'h2222_2222_2222_2222, 0, 2, 21};
    vecs[5] = '{64'h0, 64'h9D3B_6E21_F0A4_5C87, 64'h9D3B_6E21_F0A4_5C87,
                64'hCCCC_CCCC_CCCC_CCCC, 15, 1, 20};

    rst_n_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    rnd_valid_i = 1'b1;
    rnd_i = 8'h00;
    state1_i = '0;
    state2_i = '0;
    state3_i = '0;
    g_base = 0;
    g_bub_k = 0;
    g_bub_left = 0;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_ctrl", {41'd0, out_valid_o, busy_o, rnd_ack_o, sb_in1_o, sb_in2_o, sb_in3_o, sb_r_o}, 64'd0);
    chk("reset_state", state1_o | state2_o | state3_o, 64'd0);
    rst_n_i = 1'b1;
    #1;
    chk("reset_ready", {63'd0, in_ready_o}, 64'd1);

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Hold DONE for 10 cycles with a new request pending, then release back-to-back.
    out_ready_i = 1'b0;
    run_op(vecs[1], "hold");
    h1 = state1_o;
    h2 = state2_o;
    h3 = state3_o;
    state1_i = '0;
    state2_i = '0;
    state3_i = '0;
    in_valid_i = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #2;
      if (state1_o !== h1 || state2_o !== h2 || state3_o !== h3 ||
          out_valid_o !== 1'b1 || busy_o !== 1'b1 || in_ready_o !== 1'b0 || rnd_ack_o !== 1'b0)
        ok = 1'b0;
    end
    chk("hold_stable", {63'd0, ok}, 64'd1);
    g_base = ack_total;
    g_bub_left = 0;
    out_ready_i = 1'b1;
    @(posedge clk);
    #2;
    chk("b2b_idle", {61'd0, in_ready_o, out_valid_o, busy_o}, 64'h4);
    wait_result(1000, lat);
    chk("b2b_latency", 64'(lat), 64'd19);
    chk("b2b_xor", state1_o ^ state2_o ^ state3_o, 64'hCCCC_CCCC_CCCC_CCCC);
    @(posedge clk);
    #2;

    // Reset pulse while draining.
    start_op(vecs[3]);
    wait_result(17, lat);
    chk("drain_no_result", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("drain_busy", {62'd0, busy_o, out_valid_o}, 64'h2);
    chk("drain_partial", {63'd0, (state1_o ^ state2_o ^ state3_o) != 64'd0}, 64'd1);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("drain_rst_ctrl", {41'd0, out_valid_o, busy_o, rnd_ack_o, sb_in1_o, sb_in2_o, sb_in3_o, sb_r_o}, 64'd0);
    chk("drain_rst_state", state1_o | state2_o | state3_o, 64'd0);
    @(posedge clk);
    #2;
    rst_n_i = 1'b1;
    #1;
    chk("drain_rst_ready", {63'd0, in_ready_o}, 64'd1);
    run_op(vecs[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/present_sbox_layer_ctrl.md
PRESENT_SBOX_LAYER_CTRL -- requirements
Module: present_sbox_layer_ctrl

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 3: cycles from nibble shares on sb_in*_o to result shares on sb_out*_i; legal range 2..8.
REQ-002 SHALL have parameter R_DELAY, default 1: cycles from nibble on sb_in*_o to its randomness needed on sb_r_o; 0 <= R_DELAY < SBOX_LAT.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports state1_i/state2_i/state3_i, input, 64 each: three Boolean shares of the cipher state.
REQ-006 SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1): input handshake.
REQ-007 SHALL have ports rnd_i (input, 8), rnd_valid_i (input, 1) and rnd_ack_o (output, 1): fresh randomness from the PRNG; one 8-bit word per nibble.
REQ-008 SHALL have ports sb_in1_o/sb_in2_o/sb_in3_o, output, 4 each, and sb_r_o, output, 8: drive the masked S-box.
REQ-009 SHALL have ports sb_out1_i/sb_out2_i/sb_out3_i, input, 4 each: masked S-box results.
REQ-010 SHALL have ports state1_o/state2_o/state3_o, output, 64 each: substituted state shares.
REQ-011 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1): output handshake; busy_o (output, 1): high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, FEED, DRAIN, DONE.
REQ-013 SHALL assert in_ready_o only in IDLE; on in_valid_i && in_ready_o, latch all three shares and go to FEED with feed index 0.
REQ-014 SHALL, in FEED, present nibble k (bits 4k+3:4k of each share, k = 0 first) on sb_in*_o only in a cycle where rnd_valid_i = 1; that cycle asserts rnd_ack_o and increments k.
REQ-015 SHALL, in FEED with rnd_valid_i = 0, insert a bubble: sb_in*_o = 0, rnd_ack_o = 0, k unchanged.
REQ-016 SHALL drive sb_in*_o = 0 in every cycle without a fed nibble, and never hold a share value stale.
REQ-017 SHALL delay the acknowledged rnd_i word R_DELAY cycles and drive it on sb_r_o in exactly the cycle its nibble reaches the randomness stage; otherwise sb_r_o = 0.
REQ-018 SHALL track fed nibbles with a SBOX_LAT-deep valid/index token pipeline and capture sb_out*_i into output nibble index at the edge where the token exits.
REQ-019 SHALL go FEED -> DRAIN after nibble 15 is fed, DRAIN -> DONE at the edge capturing nibble 15.
REQ-020 SHALL hold out_valid_o = 1 and stable state*_o in DONE until out_ready_i = 1, then return to IDLE next edge.
REQ-021 SHALL, with rnd_valid_i constantly 1, raise out_valid_o exactly 16 + SBOX_LAT edges after the acceptance edge; each bubble adds one cycle.
REQ-022 SHALL ignore in_valid_i while busy_o = 1; in-flight data is never overwritten.
REQ-023 SHALL never combine shares of one nibble, nor different shares of different nibbles, in any register or logic cone.

Reset
REQ-024 SHALL, on rst_n_i = 0 at any time including mid-FEED or DRAIN, immediately enter IDLE, clear tokens, counters and state registers.
REQ-025 SHALL reset outputs to: in_ready_o = 1 after release, out_valid_o = 0, busy_o = 0, rnd_ack_o = 0, sb_in*_o = 0, sb_r_o = 0, state*_o = 0.

Structure
REQ-026 SHALL place FSM state enum, NIBBLES = 16 and share/nibble width constants in a shared package present_masked_pkg.
REQ-027 SHALL instantiate one sub-module, present_token_pipe (valid + 4-bit index shift register, depth SBOX_LAT); the S-box itself stays outside.

Verification
REQ-028 All shares 0, rnd_valid_i = 1 -> out_valid_o at edge 19 (SBOX_LAT 3); XOR of output shares = 64'hCCCC_CCCC_CCCC_CCCC.
REQ-029 Shares 64'h0123456789ABCDEF, random, random (unmasked = XOR) -> output XOR = PRESENT S-box of each unmasked nibble; compare against golden model.
REQ-030 rnd_valid_i low for 5 cycles at k = 7 -> five zero-input bubbles, correct result, out_valid_o at edge 24, sb_r_o aligned per R_DELAY.
REQ-031 out_ready_i held 0 for 10 cycles in DONE -> outputs stable, in_valid_i ignored; accepted one cycle after out_ready_i = 1.
REQ-032 rst_n_i pulsed low during DRAIN -> all outputs zero immediately; next operation with shares 0 yields 64'hCCCC_CCCC_CCCC_CCCC.
REQ-033 Back-to-back: in_valid_i held high across two operations -> second accepted one cycle after first handshake completes.
